// File: rtl/ieee_adder_issue_queue_pkg.sv
// Shared field layout and special-flag indices for the adder issue queue.
// IEEE-754 single precision operands.
package ieee_adder_issue_queue_pkg;

  localparam int TOTALBITS       = 32;
  localparam int SIGN_BIT        = 31;
  localparam int EXPO_LASTBIT    = 30;
  localparam int EXPO_FIRSTBIT   = 23;
  localparam int SIGNIF_LASTBIT  = 22;
  localparam int SIGNIF_FIRSTBIT = 0;

  localparam int ISSUE_SPECIAL_W = 5;
  localparam int SPC_A_NAN       = 4;
  localparam int SPC_B_NAN       = 3;
  localparam int SPC_A_INF       = 2;
  localparam int SPC_B_INF       = 1;
  localparam int SPC_EFF_SUB     = 0;

  typedef logic [TOTALBITS-1:0]       fp_t;
  typedef logic [ISSUE_SPECIAL_W-1:0] spc_t;

endpackage

// File: rtl/ieee_operand_classify.sv
// Combinational classifier: IEEE-754 single -> sign, NaN, infinity.
module ieee_operand_classify
  import ieee_adder_issue_queue_pkg::*;
(
  input  fp_t  num,
  output logic sign,
  output logic is_nan,
  output logic is_inf
);

  logic exp_ones;
  logic frac_zero;

  assign exp_ones  = &num[EXPO_LASTBIT:EXPO_FIRSTBIT];
  assign frac_zero = (num[SIGNIF_LASTBIT:SIGNIF_FIRSTBIT] == '0);
  assign sign      = num[SIGN_BIT];
  assign is_nan    = exp_ones & ~frac_zero;
  assign is_inf    = exp_ones & frac_zero;

endmodule

// File: rtl/ieee_adder_issue_queue.sv
// Tagged FWFT operand queue feeding the single-precision adder.
// IEEE_ISSUE_SPECIAL_DETECT_EN stores push-time special-operand flags.
module ieee_adder_issue_queue
  import ieee_adder_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  fp_t                      in_a,
  input  fp_t                      in_b,
  input  logic                     in_add_sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output fp_t                      out_a,
  output fp_t                      out_b,
  output logic                     out_add_sub,
  output logic [TAG_W-1:0]         out_tag,
  output spc_t                     out_special,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    occ;
  logic [TAG_W-1:0] next_tag;

  fp_t              mem_a   [DEPTH];
  fp_t              mem_b   [DEPTH];
  logic             mem_op  [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];

  logic push;
  logic pop;

  assign in_ready  = (occ != CW'(DEPTH));
  assign out_valid = (occ != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = occ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      next_tag <= '0;
    end else if (flush) begin
      occ    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PW'(1);
        next_tag <= next_tag + TAG_W'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage carries no reset; contents are only observed while valid.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_a[wr_ptr]   <= in_a;
      mem_b[wr_ptr]   <= in_b;
      mem_op[wr_ptr]  <= in_add_sub;
      mem_tag[wr_ptr] <= next_tag;
    end
  end

  assign out_a       = mem_a[rd_ptr];
  assign out_b       = mem_b[rd_ptr];
  assign out_add_sub = mem_op[rd_ptr];
  assign out_tag     = mem_tag[rd_ptr];

`ifdef IEEE_ISSUE_SPECIAL_DETECT_EN
  logic a_sign, a_nan, a_inf;
  logic b_sign, b_nan, b_inf;
  spc_t spc_in;
  spc_t mem_spc [DEPTH];

  ieee_operand_classify u_cls_a (
    .num    (in_a),
    .sign   (a_sign),
    .is_nan (a_nan),
    .is_inf (a_inf)
  );

  ieee_operand_classify u_cls_b (
    .num    (in_b),
    .sign   (b_sign),
    .is_nan (b_nan),
    .is_inf (b_inf)
  );

  always_comb begin
    spc_in              = '0;
    spc_in[SPC_A_NAN]   = a_nan;
    spc_in[SPC_B_NAN]   = b_nan;
    spc_in[SPC_A_INF]   = a_inf;
    spc_in[SPC_B_INF]   = b_inf;
    spc_in[SPC_EFF_SUB] = a_sign ^ b_sign ^ in_add_sub;
  end

  always_ff @(posedge clk) begin
    if (push && !flush)
      mem_spc[wr_ptr] <= spc_in;
  end

  assign out_special = mem_spc[rd_ptr];
`else
  assign out_special = '0;
`endif

endmodule

// File: tb/tb_ieee_adder_issue_queue.sv
// Randomized bench for ieee_adder_issue_queue against a queue-based model.
// Honours IEEE_ISSUE_SPECIAL_DETECT_EN for the expected special flags.
module tb_ieee_adder_issue_queue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_add_sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic        out_add_sub;
  logic [3:0]  out_tag;
  logic [4:0]  out_special;
  logic [2:0]  count;

  ieee_adder_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_add_sub  (in_add_sub),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_add_sub (out_add_sub),
    .out_tag     (out_tag),
    .out_special (out_special),
    .count       (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [3:0]  tag;
    logic [4:0]  spc;
  } ent_t;

  ent_t q[$];
  int   mtag;
  int   total;
  int   bad;

  function automatic logic [4:0] spc_of(logic [31:0] a, logic [31:0] b,
                                        logic op);
`ifdef IEEE_ISSUE_SPECIAL_DETECT_EN
    int ea = (a >> 23) & 255;
    int eb = (b >> 23) & 255;
    int fa = a & 32'h7FFFFF;
    int fb = b & 32'h7FFFFF;
    logic an = (ea == 255) && (fa != 0);
    logic bn = (eb == 255) && (fb != 0);
    logic ai = (ea == 255) && (fa == 0);
    logic bi = (eb == 255) && (fb == 0);
    logic es = a[31] ^ b[31] ^ op;
    return {an, bn, ai, bi, es};
`else
    return 5'b0;
`endif
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v = $urandom;
    case ($urandom_range(0, 4))
      0: v[30:23] = 8'hFF;
      1: begin v[30:23] = 8'hFF; v[22:0] = '0; end
      default: ;
    endcase
    return v;
  endfunction

  // Advance one clock and apply the queue rules to the model.
  task automatic tick();
    bit   p_push = in_valid && (q.size() < DEPTH);
    bit   p_pop  = (q.size() > 0) && out_ready;
    bit   p_fl   = flush;
    ent_t e;
    @(posedge clk);
    #1;
    if (p_fl) begin
      q.delete();
    end else begin
      if (p_pop) void'(q.pop_front());
      if (p_push) begin
        e.a   = in_a;
        e.b   = in_b;
        e.op  = in_add_sub;
        e.tag = 4'(mtag);
        e.spc = spc_of(in_a, in_b, in_add_sub);
        q.push_back(e);
        mtag = (mtag + 1) % (1 << TAG_W);
      end
    end
  endtask

  task automatic rand_in();
    in_a       = rand_fp();
    in_b       = rand_fp();
    in_add_sub = 1'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 0; in_valid = 0; out_ready = 0;
    in_a = 0; in_b = 0; in_add_sub = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    q.delete(); mtag = 0;
    total++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset: count=%0d vld=%b rdy=%b want 0/0/1",
               count, out_valid, in_ready);
    end
  endtask

  task automatic test_first_push();
    in_a = 32'h3F800000; in_b = 32'h40000000; in_add_sub = 0;
    in_valid = 1; out_ready = 0;
    tick();
    in_valid = 0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_tag !== 4'd0 || count !== 3'd1 ||
          out_a !== 32'h3F800000 || out_b !== 32'h40000000 ||
          out_add_sub !== 1'b0) begin
        bad++;
        $display("FAIL first_push[%0d]: vld=%b tag=%0d cnt=%0d a=%h b=%h op=%b want 1/0/1/3f800000/40000000/0",
                 i, out_valid, out_tag, count, out_a, out_b, out_add_sub);
      end
      tick();
    end
  endtask

  task automatic test_fill();
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      rand_in();
      tick();
      total++;
      if (count !== 3'(q.size()) || in_ready !== (q.size() != DEPTH) ||
          (q.size() > 0 && (out_a !== q[0].a || out_tag !== q[0].tag))) begin
        bad++;
        $display("FAIL fill[%0d]: cnt=%0d rdy=%b a=%h tag=%0d want cnt=%0d",
                 i, count, in_ready, out_a, out_tag, q.size());
      end
    end
    total++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL full: cnt=%0d rdy=%b want 4/0", count, in_ready);
    end
    rand_in(); out_ready = 1;
    tick();
    total++;
    if (count !== 3'd3 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL full_pop: cnt=%0d rdy=%b want 3/1", count, in_ready);
    end
    out_ready = 0;
    tick();
    in_valid = 0;
    total++;
    if (count !== 3'd4 || out_tag !== q[0].tag || out_b !== q[0].b) begin
      bad++;
      $display("FAIL refill: cnt=%0d tag=%0d want 4/%0d",
               count, out_tag, q[0].tag);
    end
  endtask

  task automatic test_back_to_back();
    int last_tag;
    in_valid = 0; out_ready = 1;
    while (q.size() > 0) tick();
    out_ready = 0; in_valid = 1; rand_in();
    tick();
    out_ready = 1;
    last_tag = -1;
    for (int i = 0; i < 40; i++) begin
      total++;
      if (count !== 3'd1 || out_valid !== 1'b1 || out_a !== q[0].a ||
          out_b !== q[0].b || out_add_sub !== q[0].op ||
          out_tag !== q[0].tag ||
          (last_tag >= 0 && int'(out_tag) != (last_tag + 1) % 16)) begin
        bad++;
        $display("FAIL b2b[%0d]: cnt=%0d tag=%0d a=%h want cnt=1 tag=%0d a=%h",
                 i, count, out_tag, out_a, q[0].tag, q[0].a);
      end
      last_tag = out_tag;
      rand_in();
      tick();
    end
    in_valid = 0; out_ready = 0;
  endtask

  task automatic test_flush();
    int keep;
    in_valid = 1; out_ready = 0;
    while (q.size() < 3) begin rand_in(); tick(); end
    rand_in(); out_ready = 1; flush = 1;
    keep = mtag;
    tick();
    flush = 0; out_ready = 0;
    total++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush: cnt=%0d vld=%b want 0/0", count, out_valid);
    end
    rand_in();
    tick();
    in_valid = 0;
    total++;
    if (out_valid !== 1'b1 || out_tag !== 4'(keep) || out_a !== q[0].a) begin
      bad++;
      $display("FAIL flush_tag: vld=%b tag=%0d want 1/%0d",
               out_valid, out_tag, keep);
    end
  endtask

  task automatic test_special();
    logic [4:0] want;
`ifdef IEEE_ISSUE_SPECIAL_DETECT_EN
    want = 5'b10010;
`else
    want = 5'b00000;
`endif
    in_valid = 0; out_ready = 1;
    while (q.size() > 0) tick();
    out_ready = 0; in_valid = 1;
    in_a = 32'h7FC00000; in_b = 32'hFF800000; in_add_sub = 1;
    tick();
    in_valid = 0;
    total++;
    if (out_valid !== 1'b1 || out_special !== want) begin
      bad++;
      $display("FAIL special: vld=%b spc=%b want 1/%b",
               out_valid, out_special, want);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = 1'($urandom_range(0, 30) == 0);
      rand_in();
      tick();
      total++;
      if (count !== 3'(q.size()) || out_valid !== (q.size() != 0) ||
          in_ready !== (q.size() != DEPTH)) begin
        bad++;
        $display("FAIL rand_stat[%0d]: cnt=%0d vld=%b rdy=%b want cnt=%0d",
                 i, count, out_valid, in_ready, q.size());
      end else if (q.size() > 0) begin
        total++;
        if (out_a !== q[0].a || out_b !== q[0].b ||
            out_add_sub !== q[0].op || out_tag !== q[0].tag ||
            out_special !== q[0].spc) begin
          bad++;
          $display("FAIL rand_data[%0d]: a=%h b=%h op=%b tag=%0d spc=%b want %h %h %b %0d %b",
                   i, out_a, out_b, out_add_sub, out_tag, out_special,
                   q[0].a, q[0].b, q[0].op, q[0].tag, q[0].spc);
        end
      end
    end
    flush = 0; in_valid = 0; out_ready = 0;
  endtask

  task automatic test_async_reset();
    in_valid = 0; out_ready = 1;
    while (q.size() > 0) tick();
    out_ready = 0; in_valid = 1;
    while (q.size() < 2) begin rand_in(); tick(); end
    in_valid = 0;
    #2 rst = 1'b1;
    #1;
    q.delete(); mtag = 0;
    total++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      bad++;
      $display("FAIL async_rst: vld=%b cnt=%0d want 0/0", out_valid, count);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_ready: rdy=%b want 1", in_ready);
    end
    in_valid = 1; rand_in();
    tick();
    in_valid = 0;
    total++;
    if (out_valid !== 1'b1 || out_tag !== 4'd0 || out_a !== q[0].a) begin
      bad++;
      $display("FAIL rst_tag: vld=%b tag=%0d want 1/0", out_valid, out_tag);
    end
  endtask

  initial begin
    total = 0; bad = 0; mtag = 0;
    test_reset();
    test_first_push();
    test_fill();
    test_back_to_back();
    test_flush();
    test_special();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
